vga_rx_timing: RTL and testbench
================================

Name: vga_rx_timing

Overview:
Receive-side counterpart of the VGA timing generator; sits on the sink end of a VGA pixel link, for example a capture or loopback path.
Samples hsync/vsync/valid and 8-bit RGB on pclk and recovers per-pixel coordinates.
Measures line and frame periods against the configured 640x480 timing, maintains a lock state and emits a write strobe with packed 12-bit pixels for a frame buffer.

Parameters:
H_TOTAL, 800, expected pclk cycles per line (hsync fall to hsync fall)
V_TOTAL, 525, expected lines per frame (vsync fall to vsync fall)
H_ACTIVE, 640, expected valid pixels per line
V_ACTIVE, 480, expected lines containing valid pixels per frame
LOCK_FRAMES, 2, consecutive clean frames required to assert locked (1..15)

Ports:
pclk  input  1  pixel clock, 25 MHz
reset_n  input  1  asynchronous active-low reset
hsync  input  1  line sync, active-low pulse
vsync  input  1  frame sync, active-low pulse
valid  input  1  data-enable; high during active pixels
vga_r  input  8  red
vga_g  input  8  green
vga_b  input  8  blue
h_addr  output  10  recovered column of pix_data
v_addr  output  10  recovered row of pix_data
pix_data  output  12  {r[7:4],g[7:4],b[7:4]}
pix_we  output  1  pix_data/h_addr/v_addr valid this cycle
line_len  output  10  last measured line period in pclk cycles (saturating at 1023)
frame_lines  output  10  last measured frame length in lines
locked  output  1  timing matches parameters for LOCK_FRAMES frames
timing_err  output  1  one-cycle pulse on any measured mismatch

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0; state SEARCH; all counters 0.
- Input register stage: all inputs registered once. Edge detection runs on the registered copies (previous vs current).
- hsync fall: latch hcnt+1 into line_len, then clear hcnt. hcnt saturates at 1023.
- hsync fall, line-level checks: mismatch if line_len != H_TOTAL, or if the per-line valid count != H_ACTIVE when the count is nonzero.
- vsync fall: latch line count into frame_lines, clear the line counter and v_addr. Mismatch if frame_lines != V_TOTAL or active-line count != V_ACTIVE.
- hsync fall and vsync fall in the same cycle: process the line first, then the frame; the frame begins at line 0.
- Pixel path: pix_we = registered valid. h_addr counts valid cycles within the line and clears on valid fall. v_addr increments on each valid fall and clears on vsync fall.
- Pixel path latency: 2 pclk from input pins to pix_we/pix_data.
- Output gating: pix_we is forced 0 unless state is LOCKED, or state is CHECK and the frame count is at least 1.
- Column overflow: h_addr saturates at 1023; further pixels in that line raise a mismatch.
- State machine:
  - SEARCH: wait for first vsync fall -> CHECK, clean-frame count = 0.
  - CHECK: each vsync fall with no mismatch in that frame increments the count. When count == LOCK_FRAMES -> LOCKED, locked=1. Any mismatch -> SEARCH.
  - LOCKED: any mismatch -> SEARCH, locked=0 in the same cycle as the timing_err pulse.
- No sync activity: if hcnt saturates (no hsync for 1023 cycles), flag a mismatch and go to SEARCH. This covers cable unplug.
- timing_err: one-cycle pulse for every mismatch event, regardless of state.

Optional Feature:
VGA_RX_CHECKSUM_EN:
- When defined: adds output frame_sum [15:0] and frame_sum_vld [0:0].
  - frame_sum is a 16-bit wrap-around sum of pix_data over all pix_we cycles of a frame.
  - It is latched at vsync fall; frame_sum_vld pulses for 1 cycle at that point.
  - Both reset to 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Standard 640x480 source, 4 frames: locked rises at 2nd vsync fall after the first. line_len=800, frame_lines=525, timing_err never pulses.
- Locked, constant pixel 0xFF_80_10: exactly 640 pix_we per line, h_addr 0..639, v_addr 0..479, pix_data=0xF81.
- Locked, one line lengthened to 801 cycles: timing_err pulses once, locked falls the same cycle, line_len=801; relock after 2 clean frames.
- hsync held high for 1100 cycles while locked: timing_err at hcnt saturation, state SEARCH, pix_we stays 0.
- reset_n pulsed low mid-line while locked: all outputs 0 immediately (asynchronous); relock requires a fresh SEARCH→CHECK sequence.
- With VGA_RX_CHECKSUM_EN, constant pixel 0x001 over one frame: frame_sum = 307200 mod 65536 = 0xB000, with frame_sum_vld pulsing once at vsync fall.

Source files
------------

// File: rtl/vga_rx_timing.sv
// VGA sink-side timing recovery: registers the link, measures line/frame periods,
// tracks lock and emits packed 12-bit pixels with recovered coordinates.
// Optional per-frame pixel checksum outputs are enabled by defining VGA_RX_CHECKSUM_EN.
module vga_rx_timing #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic [11:0] pix_data,
  output logic        pix_we,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        timing_err
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        frame_sum_vld
`endif
);

  localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [11:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {r[7:4], g[7:4], b[7:4]};
  endfunction

  // Reset is asserted asynchronously but released in step with pclk.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Stage p0: input registers; p1 holds the previous p0 sample for edge detection.
  logic       hs_p0, vs_p0, vld_p0;
  logic       hs_p1, vs_p1, vld_p1;
  logic [7:0] r_p0, g_p0, b_p0;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
      vld_p0 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
      r_p0   <= '0;
      g_p0   <= '0;
      b_p0   <= '0;
    end else begin
      hs_p0  <= hsync;
      vs_p0  <= vsync;
      vld_p0 <= valid;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vld_p1 <= vld_p0;
      r_p0   <= vga_r;
      g_p0   <= vga_g;
      b_p0   <= vga_b;
    end
  end

  logic hs_fall, vs_fall, vld_fall;

  assign hs_fall  = hs_p1 & ~hs_p0;
  assign vs_fall  = vs_p1 & ~vs_p0;
  assign vld_fall = vld_p1 & ~vld_p0;

  logic [9:0] hcnt, vld_cnt, lcnt, row, col;
  logic       have_line, col_full;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [9:0] line_len_new, lines_new, act_lines;
  logic       line_bad, frame_bad, sat_hit, col_ovf, mismatch;

  // The first hsync fall after reset or sync loss only starts a reference line.
  always_comb begin
    line_len_new = sat_inc10(hcnt);
    lines_new    = hs_fall ? sat_inc10(lcnt) : lcnt;
    act_lines    = vld_fall ? sat_inc10(row) : row;
    line_bad     = hs_fall && have_line &&
                   ((line_len_new != H_TOT) || ((vld_cnt != 10'd0) && (vld_cnt != H_ACT)));
    frame_bad    = vs_fall && (state_q != SEARCH) &&
                   ((lines_new != V_TOT) || (act_lines != V_ACT));
    sat_hit      = !hs_fall && (hcnt == 10'h3FE);
    col_ovf      = vld_p0 && col_full;
    mismatch     = line_bad | frame_bad | sat_hit | col_ovf;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mismatch) begin
      state_d = SEARCH;
      cnt_d   = '0;
    end else if (vs_fall) begin
      case (state_q)
        SEARCH: begin
          state_d = CHECK;
          cnt_d   = '0;
        end
        CHECK: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == LOCK_N) state_d = LOCKED;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

  logic pix_gate;
  assign pix_gate = (state_q == LOCKED) || ((state_q == CHECK) && (cnt_q != 4'd0));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vld_cnt     <= '0;
      have_line   <= 1'b0;
      lcnt        <= '0;
      row         <= '0;
      col         <= '0;
      col_full    <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      timing_err  <= 1'b0;
    end else begin
      timing_err <= mismatch;
      if (hs_fall) begin
        hcnt      <= '0;
        line_len  <= line_len_new;
        vld_cnt   <= {9'd0, vld_p0};
        have_line <= 1'b1;
      end else begin
        hcnt <= sat_inc10(hcnt);
        if (vld_p0)  vld_cnt   <= sat_inc10(vld_cnt);
        if (sat_hit) have_line <= 1'b0;
      end
      if (vs_fall) begin
        lcnt        <= '0;
        frame_lines <= lines_new;
      end else begin
        lcnt <= lines_new;
      end
      if (vs_fall)       row <= '0;
      else if (vld_fall) row <= sat_inc10(row);
      if (vld_fall) begin
        col      <= '0;
        col_full <= 1'b0;
      end else if (vld_p0) begin
        if (col == 10'h3FF) col_full <= 1'b1;
        else                col <= col + 10'd1;
      end
    end
  end

  // Stage p1: pixel output registers, two pclk after the pins.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_we   <= 1'b0;
      h_addr   <= '0;
      v_addr   <= '0;
      pix_data <= '0;
    end else begin
      pix_we <= vld_p0 & pix_gate;
      if (vld_p0 && pix_gate) begin
        h_addr   <= col;
        v_addr   <= row;
        pix_data <= pack_rgb(r_p0, g_p0, b_p0);
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] sum_acc, sum_add;

  assign sum_add = pix_we ? {4'd0, pix_data} : 16'd0;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc       <= '0;
      frame_sum     <= '0;
      frame_sum_vld <= 1'b0;
    end else begin
      frame_sum_vld <= vs_fall;
      if (vs_fall) begin
        frame_sum <= sum_acc + sum_add;
        sum_acc   <= '0;
      end else begin
        sum_acc <= sum_acc + sum_add;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_rx_timing.sv
// Scoreboard bench for vga_rx_timing on a scaled-down raster (40x12 total, 24x8 active).
// Build with VGA_RX_CHECKSUM_EN defined to also exercise the frame checksum outputs.
module tb_vga_rx_timing;

  localparam int HT = 40;
  localparam int HA = 24;
  localparam int VT = 12;
  localparam int VA = 8;
  localparam int LF = 2;

  logic        pclk    = 1'b0;
  logic        reset_n = 1'b1;
  logic        hsync   = 1'b1;
  logic        vsync   = 1'b1;
  logic        valid   = 1'b0;
  logic [7:0]  vga_r   = '0;
  logic [7:0]  vga_g   = '0;
  logic [7:0]  vga_b   = '0;
  logic [9:0]  h_addr, v_addr, line_len, frame_lines;
  logic [11:0] pix_data;
  logic        pix_we, locked, timing_err;
`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic        frame_sum_vld;
`endif

  vga_rx_timing #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .h_addr(h_addr), .v_addr(v_addr), .pix_data(pix_data), .pix_we(pix_we),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked), .timing_err(timing_err)
`ifdef VGA_RX_CHECKSUM_EN
    , .frame_sum(frame_sum), .frame_sum_vld(frame_sum_vld)
`endif
  );

  always #20 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_q[$];

  int   err_cnt         = 0;
  int   fsv_cnt         = 0;
  int   lock_rise_cyc   = -1;
  int   vs_fall_cyc     = 0;
  int   err_line_len    = 0;
  logic err_locked      = 1'b0;
  logic err_prev_locked = 1'b0;
  logic locked_d        = 1'b0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge pclk);
      if (pix_we) begin
        if (exp_q.size() == 0) begin
          check_val("pix_we_unexpected", {31'd0, pix_we}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("pixel", {v_addr, h_addr, pix_data}, e);
        end
      end
      if (timing_err) begin
        err_cnt++;
        err_line_len    = int'(line_len);
        err_locked      = locked;
        err_prev_locked = locked_d;
      end
      if (locked && !locked_d) lock_rise_cyc = cyc;
      locked_d = locked;
`ifdef VGA_RX_CHECKSUM_EN
      if (frame_sum_vld) fsv_cnt++;
`endif
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      hsync = 1'b1;
      vsync = 1'b1;
      valid = 1'b0;
      vga_r = '0;
      vga_g = '0;
      vga_b = '0;
    end
  endtask

  // Line: hsync low for 4 cycles, active pixels at cycles 8..31; frame: vsync low on lines 0-1, active lines 3..10.
  task automatic drive_line(input int y, input int len, input int stop, input bit open, input int mode);
    int x, row;
    for (int c = 0; c < len && c < stop; c++) begin
      @(negedge pclk);
      hsync = (c < 4) ? 1'b0 : 1'b1;
      vsync = (y < 2) ? 1'b0 : 1'b1;
      if (y == 0 && c == 0) vs_fall_cyc = cyc;
      valid = (y >= 3) && (y < 3 + VA) && (c >= 8) && (c < 8 + HA);
      if (valid) begin
        x   = c - 8;
        row = y - 3;
        case (mode)
          0: begin vga_r = 8'hFF; vga_g = 8'h80; vga_b = 8'h10; end
          1: begin
            vga_r = 8'(x * 11 + row * 37);
            vga_g = 8'(x * 5 + row * 19 + 64);
            vga_b = 8'(255 - x * 7);
          end
          default: begin vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h10; end
        endcase
        if (open) exp_q.push_back({10'(row), 10'(x), vga_r[7:4], vga_g[7:4], vga_b[7:4]});
      end else begin
        vga_r = '0;
        vga_g = '0;
        vga_b = '0;
      end
    end
  endtask

  task automatic drive_frame(input int open_lines, input int mode, input int long_y);
    for (int y = 0; y < VT; y++)
      drive_line(y, (y == long_y) ? HT + 1 : HT, HT + 2, (y < open_lines), mode);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

  initial begin
    int fsv_before;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge pclk);
    check_val("rst_pix_we", {31'd0, pix_we}, 32'd0);
    check_val("rst_locked", {31'd0, locked}, 32'd0);
    check_val("rst_timing_err", {31'd0, timing_err}, 32'd0);
    check_val("rst_line_len", 32'(line_len), 32'd0);
    check_val("rst_frame_lines", 32'(frame_lines), 32'd0);
    check_val("rst_h_addr", 32'(h_addr), 32'd0);
    check_val("rst_v_addr", 32'(v_addr), 32'd0);
    check_val("rst_pix_data", 32'(pix_data), 32'd0);
    reset_n = 1'b1;
    idle(6);

    // Clean source: lock rises at the third vsync fall, pixels open from the second frame.
    drive_frame(0, 1, -1);
    check_val("locked_after_f0", {31'd0, locked}, 32'd0);
    drive_frame(VT, 1, -1);
    check_val("locked_after_f1", {31'd0, locked}, 32'd0);
    drive_frame(VT, 1, -1);
    check_val("locked_after_f2", {31'd0, locked}, 32'd1);
    check_val("lock_latency", 32'(lock_rise_cyc - vs_fall_cyc), 32'd2);
    drive_frame(VT, 0, -1);
    check_val("line_len_std", 32'(line_len), 32'(HT));
    check_val("frame_lines_std", 32'(frame_lines), 32'(VT));
    check_val("err_cnt_clean", 32'(err_cnt), 32'd0);

    // One line one cycle long while locked.
    drive_frame(6, 1, 5);
    check_val("err_cnt_long", 32'(err_cnt), 32'd1);
    check_val("err_line_len", 32'(err_line_len), 32'(HT + 1));
    check_val("err_locked_same_cycle", {31'd0, err_locked}, 32'd0);
    check_val("err_prev_locked", {31'd0, err_prev_locked}, 32'd1);
    drive_frame(0, 1, -1);
    check_val("relock_f0", {31'd0, locked}, 32'd0);
    drive_frame(VT, 1, -1);
    check_val("relock_f1", {31'd0, locked}, 32'd0);
    drive_frame(VT, 1, -1);
    check_val("relock_f2", {31'd0, locked}, 32'd1);
    check_val("err_cnt_relock", 32'(err_cnt), 32'd1);

    // Sync loss: hsync held high past counter saturation.
    idle(1100);
    check_val("err_cnt_nosync", 32'(err_cnt), 32'd2);
    check_val("locked_nosync", {31'd0, locked}, 32'd0);
    drive_frame(0, 1, -1);
    drive_frame(VT, 1, -1);
    check_val("nosync_relock_f1", {31'd0, locked}, 32'd0);
    drive_frame(VT, 1, -1);
    check_val("nosync_relock_f2", {31'd0, locked}, 32'd1);

    // Asynchronous reset in the middle of a line while locked.
    for (int y = 0; y < 5; y++) drive_line(y, HT, HT + 2, 1'b1, 1);
    drive_line(5, HT, 36, 1'b1, 1);
    check_val("locked_before_reset", {31'd0, locked}, 32'd1);
    check_val("queue_before_reset", 32'(exp_q.size()), 32'd0);
    @(negedge pclk);
    #5 reset_n = 1'b0;
    #1;
    check_val("arst_pix_we", {31'd0, pix_we}, 32'd0);
    check_val("arst_locked", {31'd0, locked}, 32'd0);
    check_val("arst_timing_err", {31'd0, timing_err}, 32'd0);
    check_val("arst_line_len", 32'(line_len), 32'd0);
    check_val("arst_frame_lines", 32'(frame_lines), 32'd0);
    check_val("arst_h_addr", 32'(h_addr), 32'd0);
    check_val("arst_v_addr", 32'(v_addr), 32'd0);
    check_val("arst_pix_data", 32'(pix_data), 32'd0);
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
    idle(6);
    drive_frame(0, 1, -1);
    check_val("rst_relock_f0", {31'd0, locked}, 32'd0);
    drive_frame(VT, 1, -1);
    check_val("rst_relock_f1", {31'd0, locked}, 32'd0);
    drive_frame(VT, 1, -1);
    check_val("rst_relock_f2", {31'd0, locked}, 32'd1);
    check_val("err_cnt_final", 32'(err_cnt), 32'd2);

`ifdef VGA_RX_CHECKSUM_EN
    // Constant pixel 0x001 over one open frame.
    drive_frame(VT, 2, -1);
    fsv_before = fsv_cnt;
    drive_frame(VT, 0, -1);
    check_val("frame_sum", 32'(frame_sum), 32'((HA * VA) % 65536));
    check_val("frame_sum_vld_pulses", 32'(fsv_cnt - fsv_before), 32'd1);
`else
    fsv_before = fsv_cnt;
`endif

    idle(4);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
